// File: rtl/colordetect_accel_pkg.sv
// Shared definitions for the colordetect accelerator arithmetic blocks.
//   udiv_state_e : control states of the sequential divider
//   DefDividendW : default dividend / quotient width
//   DefDivisorW  : default divisor / remainder width
package colordetect_accel_pkg;

    localparam int unsigned DefDividendW = 32;
    localparam int unsigned DefDivisorW  = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } udiv_state_e;

    // Number of ce cycles from operand acceptance to out_valid for a non-zero divisor.
    function automatic int unsigned udiv_latency(input int unsigned dividend_w);
        return dividend_w + 1;
    endfunction

endpackage

// File: rtl/colordetect_accel_udiv_step.sv
// One combinational radix-2 restoring division step.
//   r_i        : current partial remainder (always < divisor_i)
//   qbit_i     : next dividend bit shifted into the remainder
//   divisor_i  : divisor
//   r_next_o   : partial remainder after the trial subtraction
//   q_out_o    : resulting quotient bit
module colordetect_accel_udiv_step
    import colordetect_accel_pkg::*;
#(
    parameter int unsigned DIVISOR_W = DefDivisorW
) (
    input  logic [DIVISOR_W-1:0] r_i,
    input  logic                 qbit_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [DIVISOR_W-1:0] r_next_o,
    output logic                 q_out_o
);

    logic [DIVISOR_W:0]   trial;
    logic [DIVISOR_W-1:0] diff;

    always_comb begin
        trial = {r_i, qbit_i};
        // Compare one bit wider than the divisor so the shifted-out MSB counts.
        q_out_o = (trial >= {1'b0, divisor_i});
        // When the subtraction is taken the result is < divisor, so the low bits are exact.
        diff = trial[DIVISOR_W-1:0] - divisor_i;
        r_next_o = q_out_o ? diff : trial[DIVISOR_W-1:0];
    end

endmodule

// File: rtl/colordetect_accel_udiv_32ns_16ns_seq.sv
// Sequential unsigned divider (radix-2 restoring, one quotient bit per ce cycle).
// Used in the colordetect datapath for normalisation (channel means, ratio thresholds).
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   ce         : clock enable; all registers hold when low, no transfers occur
//   in_valid   : operand pair present          in_ready  : block accepts operands (IDLE)
//   dividend   : unsigned dividend             divisor   : unsigned divisor
//   out_valid  : result present (DONE)         out_ready : downstream takes the result
//   quotient   : unsigned quotient             remainder : unsigned remainder
//   div_zero   : result came from a zero divisor (quotient all ones, remainder = dividend low bits)
module colordetect_accel_udiv_32ns_16ns_seq
    import colordetect_accel_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = DefDividendW,
    parameter int unsigned DIVISOR_W  = DefDivisorW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_zero
);

    localparam int unsigned    CntW    = $clog2(DIVIDEND_W);
    localparam logic [CntW-1:0] CntLast = CntW'(DIVIDEND_W - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    udiv_state_e state_q, state_d;

    // Q doubles as the dividend shift register and the quotient accumulator.
    logic [DIVIDEND_W-1:0] q_q, q_d;
    // The restored partial remainder is always < divisor, so DIVISOR_W bits hold it;
    // the extra comparison bit lives inside the step.
    logic [DIVISOR_W-1:0]  r_q, r_d;
    logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  dz_q, dz_d;

    logic                  accept;
    logic                  divisor_is_zero;
    logic [DIVISOR_W-1:0]  step_r;
    logic                  step_q;

    assign accept          = ce && in_valid && (state_q == StIdle);
    assign divisor_is_zero = (divisor == '0);

    colordetect_accel_udiv_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .r_i       (r_q),
        .qbit_i    (q_q[DIVIDEND_W-1]),
        .divisor_i (divisor_q),
        .r_next_o  (step_r),
        .q_out_o   (step_q)
    );

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = divisor_is_zero ? StDone : StBusy;
                end
            end
            StBusy: begin
                if (ce && (cnt_q == '0)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (ce && out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        // in_ready is held low during reset and never depends on out_ready.
        in_ready  = reset && (state_q == StIdle);
        out_valid = (state_q == StDone);
        quotient  = q_q;
        remainder = r_q;
        div_zero  = dz_q;
    end

    // ---------------------------------------------------------------- datapath
    always_comb begin
        q_d       = q_q;
        r_d       = r_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        dz_d      = dz_q;

        if (accept) begin
            divisor_d = divisor;
            if (divisor_is_zero) begin
                q_d   = '1;
                r_d   = dividend[DIVISOR_W-1:0];
                dz_d  = 1'b1;
                cnt_d = '0;
            end else begin
                q_d   = dividend;
                r_d   = '0;
                dz_d  = 1'b0;
                cnt_d = CntLast;
            end
        end else if (ce && (state_q == StBusy)) begin
            r_d = step_r;
            q_d = {q_q[DIVIDEND_W-2:0], step_q};
            // Counter is only reloaded on acceptance; it parks at zero otherwise.
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CntOne;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q       <= '0;
            r_q       <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            dz_q      <= 1'b0;
        end else begin
            q_q       <= q_d;
            r_q       <= r_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            dz_q      <= dz_d;
        end
    end

`ifndef SYNTHESIS
    // A presented result may only be withdrawn by a handshake.
    a_valid_hold: assert property (@(posedge clk) disable iff (!reset)
        (out_valid && !(ce && out_ready)) |=> out_valid);
    a_result_stable: assert property (@(posedge clk) disable iff (!reset)
        (out_valid && !(ce && out_ready)) |=> $stable({quotient, remainder, div_zero}));
    a_state_legal: assert property (@(posedge clk) disable iff (!reset)
        state_q inside {StIdle, StBusy, StDone});
`endif

endmodule
